// File: rtl/cache_data_ram_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_data_ram_mp_pkg
// Description : Default geometry and request/response records for the
//               multi-port cache data RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_data_ram_mp_pkg;

    localparam int N_DATA_RAM_SPLIT     = 8;
    localparam int DATA_RAM_WIDTH       = 256;
    localparam int DATA_RAM_SPLIT_DEPTH = 128;
    localparam int DATA_RAM_PORTS       = 3;
    localparam int DATA_RAM_ADDR_W      = $clog2(N_DATA_RAM_SPLIT * DATA_RAM_SPLIT_DEPTH);

    typedef struct packed {
        logic                        rw;
        logic [DATA_RAM_ADDR_W-1:0]  addr;
        logic [DATA_RAM_WIDTH-1:0]   din;
        logic [DATA_RAM_WIDTH/8-1:0] byte_mask;
    } cache_ram_req_t;

    typedef struct packed {
        logic                      valid;
        logic [DATA_RAM_WIDTH-1:0] dout;
    } cache_ram_rsp_t;

    // Number of low address bits used as the split select (0 for a single split).
    function automatic int split_bits(input int n_split);
        return (n_split > 1) ? $clog2(n_split) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_data_ram_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_data_ram_mp_if
// Description : Requestor bus of the multi-port cache data RAM (all ports).
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_data_ram_mp_if #(
    parameter int N_PORTS    = 3,
    parameter int ADDR_W     = 10,
    parameter int DATA_WIDTH = 256
);
    localparam int MASK_W = DATA_WIDTH / 8;

    logic [N_PORTS-1:0]                 req_valid;
    logic [N_PORTS-1:0]                 req_ready;
    logic [N_PORTS-1:0]                 req_rw;
    logic [N_PORTS-1:0][ADDR_W-1:0]     req_addr;
    logic [N_PORTS-1:0][DATA_WIDTH-1:0] req_din;
    logic [N_PORTS-1:0][MASK_W-1:0]     req_byte_mask;
    logic [N_PORTS-1:0]                 rsp_valid;
    logic [N_PORTS-1:0][DATA_WIDTH-1:0] rsp_dout;

    modport master (
        output req_valid, req_rw, req_addr, req_din, req_byte_mask,
        input  req_ready, rsp_valid, rsp_dout
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_din, req_byte_mask,
        output req_ready, rsp_valid, rsp_dout
    );

endinterface
`default_nettype wire

// File: rtl/cache_data_ram_mp_split_arb.sv
`default_nettype none
// ============================================================================
// Module      : cache_ram_split_arb
// Description : Per-split arbiter, round-robin or fixed priority, one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ram_split_arb #(
    parameter int N_PORTS = 3,
    parameter int ARB_RR  = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [N_PORTS-1:0] i_cand,
    output logic      [N_PORTS-1:0] o_gnt
);

    localparam int c_ptr_w = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    generate
        if (ARB_RR != 0) begin : g_rr
            logic [c_ptr_w-1:0] r_ptr;
            logic [c_ptr_w-1:0] w_ptr_nxt;

            // Search starts at r_ptr and wraps; the winner's successor becomes the new start.
            always_comb begin
                logic               v_found;
                int                 v_idx;
                logic [c_ptr_w-1:0] v_sel;
                o_gnt     = '0;
                w_ptr_nxt = r_ptr;
                v_found   = 1'b0;
                v_idx     = 0;
                v_sel     = '0;
                for (int i = 0; i < N_PORTS; i++) begin
                    v_idx = int'(r_ptr) + i;
                    if (v_idx >= N_PORTS) begin
                        v_idx = v_idx - N_PORTS;
                    end
                    v_sel = c_ptr_w'(v_idx);
                    if (!v_found && i_cand[v_sel]) begin
                        v_found      = 1'b1;
                        o_gnt[v_sel] = 1'b1;
                        w_ptr_nxt    = (v_idx == N_PORTS - 1) ? '0 : c_ptr_w'(v_idx + 1);
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_ptr_nxt;
                end
            end
        end else begin : g_fixed
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;

            always_comb begin
                logic v_found;
                o_gnt   = '0;
                v_found = 1'b0;
                for (int i = 0; i < N_PORTS; i++) begin
                    if (!v_found && i_cand[i]) begin
                        v_found  = 1'b1;
                        o_gnt[i] = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/cache_data_ram_mp_sram.sv
`default_nettype none
// ============================================================================
// Module      : sram_beh_spsram
// Description : Behavioural single-port SRAM, active-low CEB/WEB/BWEB, Q held
//               until the next read.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_beh_spsram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 256
) (
    input  wire logic                     clk,
    input  wire logic                     i_ceb,
    input  wire logic                     i_web,
    input  wire logic [$clog2(DEPTH)-1:0] i_a,
    input  wire logic [WIDTH-1:0]         i_d,
    input  wire logic [WIDTH-1:0]         i_bweb,
    input  wire logic                     i_slp,
    input  wire logic                     i_pd,
    output logic      [WIDTH-1:0]         o_q
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!i_ceb && !i_slp && !i_pd) begin
            if (!i_web) begin
                r_mem[i_a] <= (r_mem[i_a] & i_bweb) | (i_d & ~i_bweb);
            end else begin
                r_q <= r_mem[i_a];
            end
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/cache_data_ram_mp.sv
`default_nettype none
// ============================================================================
// Module      : cache_data_ram_mp
// Description : Multi-port cache data RAM; N_PORTS requestors share N_SPLIT
//               single-port SRAM splits with per-split arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_data_ram_mp
    import cache_data_ram_mp_pkg::*;
#(
    parameter int N_PORTS     = DATA_RAM_PORTS,
    parameter int N_SPLIT     = N_DATA_RAM_SPLIT,
    parameter int SPLIT_DEPTH = DATA_RAM_SPLIT_DEPTH,
    parameter int DATA_WIDTH  = DATA_RAM_WIDTH,
    parameter int ARB_RR      = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cache_data_ram_mp_if.slave bus,
    input  wire logic          slp,
    input  wire logic          pwr_down
);

    localparam int c_split_bits = split_bits(N_SPLIT);
    localparam int c_sel_w      = (N_SPLIT > 1) ? c_split_bits : 1;
    localparam int c_row_w      = $clog2(SPLIT_DEPTH);
    localparam int c_addr_w     = c_split_bits + c_row_w;
    localparam int c_mask_w     = DATA_WIDTH / 8;

    logic [N_PORTS-1:0][c_sel_w-1:0]    w_split;
    logic [N_PORTS-1:0][c_row_w-1:0]    w_row;
    logic [N_SPLIT-1:0][N_PORTS-1:0]    w_cand;
    logic [N_SPLIT-1:0][N_PORTS-1:0]    w_gnt;
    logic [N_PORTS-1:0]                 w_gnt_port;
    logic                               w_accept_en;

    logic [N_SPLIT-1:0]                 w_ceb;
    logic [N_SPLIT-1:0]                 w_web;
    logic [N_SPLIT-1:0][c_row_w-1:0]    w_a;
    logic [N_SPLIT-1:0][DATA_WIDTH-1:0] w_d;
    logic [N_SPLIT-1:0][DATA_WIDTH-1:0] w_bweb;
    logic [N_SPLIT-1:0][DATA_WIDTH-1:0] w_q;

    logic [N_PORTS-1:0]                 r_rsp_valid;
    logic [N_PORTS-1:0][c_sel_w-1:0]    r_rsp_split;
    logic [N_PORTS-1:0][DATA_WIDTH-1:0] r_hold;

    generate
        for (genvar p = 0; p < N_PORTS; p++) begin : g_port
            assign w_row[p] = bus.req_addr[p][c_addr_w-1 -: c_row_w];
            if (N_SPLIT > 1) begin : g_sel
                assign w_split[p] = bus.req_addr[p][c_sel_w-1:0];
            end else begin : g_nosel
                assign w_split[p] = '0;
            end
            assign bus.rsp_dout[p] = r_rsp_valid[p] ? w_q[r_rsp_split[p]] : r_hold[p];
        end
    endgenerate

    // Gating candidates (not just ready) keeps RR pointers frozen in reset/low power.
    assign w_accept_en = ~rst & ~slp & ~pwr_down;

    always_comb begin
        w_cand = '0;
        for (int s = 0; s < N_SPLIT; s++) begin
            for (int p = 0; p < N_PORTS; p++) begin
                w_cand[s][p] = w_accept_en & bus.req_valid[p] & (w_split[p] == c_sel_w'(s));
            end
        end
    end

    generate
        for (genvar s = 0; s < N_SPLIT; s++) begin : g_split
            cache_ram_split_arb #(
                .N_PORTS (N_PORTS),
                .ARB_RR  (ARB_RR)
            ) u_arb (
                .clk     (clk),
                .rst     (rst),
                .i_cand  (w_cand[s]),
                .o_gnt   (w_gnt[s])
            );

`ifdef SRAM_TECH
            sram_tech_spsram u_sram (
                .CLK  (clk),
                .CEB  (w_ceb[s]),
                .WEB  (w_web[s]),
                .A    (w_a[s]),
                .D    (w_d[s]),
                .BWEB (w_bweb[s]),
                .SLP  (slp),
                .PD   (pwr_down),
                .Q    (w_q[s])
            );
`else
            sram_beh_spsram #(
                .DEPTH (SPLIT_DEPTH),
                .WIDTH (DATA_WIDTH)
            ) u_sram (
                .clk    (clk),
                .i_ceb  (w_ceb[s]),
                .i_web  (w_web[s]),
                .i_a    (w_a[s]),
                .i_d    (w_d[s]),
                .i_bweb (w_bweb[s]),
                .i_slp  (slp),
                .i_pd   (pwr_down),
                .o_q    (w_q[s])
            );
`endif
        end
    endgenerate

    always_comb begin
        w_gnt_port = '0;
        for (int s = 0; s < N_SPLIT; s++) begin
            w_gnt_port = w_gnt_port | w_gnt[s];
        end
    end

    assign bus.req_ready = w_gnt_port;

    // Per-split SRAM inputs come from the single granted port of that split.
    always_comb begin
        w_ceb  = '1;
        w_web  = '1;
        w_a    = '0;
        w_d    = '0;
        w_bweb = '1;
        for (int s = 0; s < N_SPLIT; s++) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (w_gnt[s][p]) begin
                    w_ceb[s] = 1'b0;
                    w_web[s] = ~bus.req_rw[p];
                    w_a[s]   = w_row[p];
                    w_d[s]   = bus.req_din[p];
                    for (int b = 0; b < c_mask_w; b++) begin
                        w_bweb[s][b*8 +: 8] = {8{~bus.req_byte_mask[p][b]}};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_split <= '0;
            r_hold      <= '0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                r_rsp_valid[p] <= w_gnt_port[p] & ~bus.req_rw[p];
                if (w_gnt_port[p] && !bus.req_rw[p]) begin
                    r_rsp_split[p] <= w_split[p];
                end
                if (r_rsp_valid[p]) begin
                    r_hold[p] <= w_q[r_rsp_split[p]];
                end
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_cache_data_ram_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_data_ram_mp
// Description : Directed bench for cache_data_ram_mp (RR and fixed-priority).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_data_ram_mp;

    localparam int c_w = 256;

    logic clk = 1'b0;
    logic rst;
    logic slp;
    logic pwr_down;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_data_ram_mp_if #(.N_PORTS(3), .ADDR_W(10), .DATA_WIDTH(c_w)) bus   ();
    cache_data_ram_mp_if #(.N_PORTS(3), .ADDR_W(10), .DATA_WIDTH(c_w)) bus_f ();

    cache_data_ram_mp #(
        .N_PORTS(3), .N_SPLIT(8), .SPLIT_DEPTH(128), .DATA_WIDTH(c_w), .ARB_RR(1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .slp(slp), .pwr_down(pwr_down)
    );

    cache_data_ram_mp #(
        .N_PORTS(3), .N_SPLIT(8), .SPLIT_DEPTH(128), .DATA_WIDTH(c_w), .ARB_RR(0)
    ) dut_f (
        .clk(clk), .rst(rst), .bus(bus_f), .slp(slp), .pwr_down(pwr_down)
    );

    typedef struct {
        int           port;
        bit           rw;
        logic [9:0]   addr;
        logic [255:0] din;
        logic [31:0]  mask;
        logic [255:0] expd;
    } vec_t;

    localparam logic [255:0] c_da   = {8{32'hA5A5_0001}};
    localparam logic [255:0] c_d10  = {8{32'h0000_0010}};
    localparam logic [255:0] c_d11  = {8{32'h0000_0011}};
    localparam logic [255:0] c_d12  = {8{32'h0000_0012}};
    localparam logic [255:0] c_d20  = {8{32'hDEAD_0020}};
    localparam logic [255:0] c_d28  = {8{32'h0000_0028}};
    localparam logic [255:0] c_d29  = {8{32'h0000_0029}};
    localparam logic [255:0] c_d40  = {8{32'hCAFE_0040}};
    localparam logic [255:0] c_dpat = {8{32'h1234_5678}};
    localparam logic [255:0] c_ones = '1;
    localparam logic [31:0]  c_full = 32'hFFFF_FFFF;

    vec_t vecs [16];

    function automatic vec_t mk(input int p, input bit rw, input logic [9:0] a,
                                input logic [255:0] d, input logic [31:0] m,
                                input logic [255:0] e);
        vec_t v;
        v.port = p; v.rw = rw; v.addr = a; v.din = d; v.mask = m; v.expd = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expd);
        n_tests++;
        if (act !== expd) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expd);
        end
    endtask

    // One request on port p; waits (bounded) for the grant, then checks the response.
    task automatic op(input vec_t v, input int idx);
        int k;
        @(negedge clk);
        bus.req_valid[v.port]     = 1'b1;
        bus.req_rw[v.port]        = v.rw;
        bus.req_addr[v.port]      = v.addr;
        bus.req_din[v.port]       = v.din;
        bus.req_byte_mask[v.port] = v.mask;
        #1;
        k = 0;
        while (!bus.req_ready[v.port] && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk($sformatf("vec%0d_ready", idx), 256'(bus.req_ready[v.port]), 256'(1));
        @(negedge clk);
        bus.req_valid[v.port] = 1'b0;
        if (!v.rw) begin
            chk($sformatf("vec%0d_rsp_valid", idx), 256'(bus.rsp_valid[v.port]), 256'(1));
            chk($sformatf("vec%0d_rsp_dout", idx), bus.rsp_dout[v.port], v.expd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst = 1'b1; slp = 1'b0; pwr_down = 1'b0;
        bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_din = '0; bus.req_byte_mask = '0;
        bus_f.req_valid = '0; bus_f.req_rw = '0; bus_f.req_addr = '0; bus_f.req_din = '0; bus_f.req_byte_mask = '0;

        vecs[0]  = mk(0, 1'b1, 10'h005, c_da,   c_full,        '0);
        vecs[1]  = mk(0, 1'b0, 10'h005, '0,     '0,            c_da);
        vecs[2]  = mk(1, 1'b1, 10'h030, '0,     c_full,        '0);
        vecs[3]  = mk(1, 1'b1, 10'h030, c_ones, 32'h0000_000F, '0);
        vecs[4]  = mk(1, 1'b0, 10'h030, '0,     '0,            256'hFFFF_FFFF);
        vecs[5]  = mk(2, 1'b1, 10'h031, c_dpat, c_full,        '0);
        vecs[6]  = mk(2, 1'b1, 10'h031, '0,     32'hF000_0000, '0);
        vecs[7]  = mk(2, 1'b0, 10'h031, '0,     '0,            {32'h0, {7{32'h1234_5678}}});
        vecs[8]  = mk(0, 1'b1, 10'h010, c_d10,  c_full,        '0);
        vecs[9]  = mk(1, 1'b1, 10'h011, c_d11,  c_full,        '0);
        vecs[10] = mk(2, 1'b1, 10'h012, c_d12,  c_full,        '0);
        vecs[11] = mk(0, 1'b1, 10'h020, c_d20,  c_full,        '0);
        vecs[12] = mk(1, 1'b1, 10'h028, c_d28,  c_full,        '0);
        vecs[13] = mk(2, 1'b1, 10'h029, c_d29,  c_full,        '0);
        vecs[14] = mk(1, 1'b0, 10'h010, '0,     '0,            c_d10);
        vecs[15] = mk(2, 1'b0, 10'h005, '0,     '0,            c_da);

        // Reset state, including ready held low with requests present
        repeat (2) @(negedge clk);
        bus.req_valid = 3'b111;
        #1;
        chk("rst_ready", 256'(bus.req_ready), '0);
        chk("rst_rsp_valid", 256'(bus.rsp_valid), '0);
        for (int p = 0; p < 3; p++) chk($sformatf("rst_dout%0d", p), bus.rsp_dout[p], '0);
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) op(vecs[i], i);

        // Three ports, three splits, same cycle
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            bus.req_valid[p] = 1'b1; bus.req_rw[p] = 1'b0; bus.req_addr[p] = 10'h010 + 10'(p);
        end
        #1;
        chk("par_ready", 256'(bus.req_ready), 256'(3'b111));
        @(negedge clk);
        bus.req_valid = '0;
        chk("par_rsp_valid", 256'(bus.rsp_valid), 256'(3'b111));
        chk("par_dout0", bus.rsp_dout[0], c_d10);
        chk("par_dout1", bus.rsp_dout[1], c_d11);
        chk("par_dout2", bus.rsp_dout[2], c_d12);

        // All ports contend for split 3 (untouched so far, pointer at 0)
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            bus.req_valid[p] = 1'b1;   bus.req_rw[p] = 1'b0;   bus.req_addr[p] = 10'h003 + 10'(8 * p);
            bus_f.req_valid[p] = 1'b1; bus_f.req_rw[p] = 1'b0; bus_f.req_addr[p] = 10'h003 + 10'(8 * p);
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rr_grant%0d", c), 256'(bus.req_ready), 256'(3'b001 << (c % 3)));
            chk($sformatf("fix_grant%0d", c), 256'(bus_f.req_ready), 256'(3'b001));
            if (c > 0) chk($sformatf("rr_rsp%0d", c), 256'(bus.rsp_valid), 256'(3'b001 << ((c - 1) % 3)));
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus_f.req_valid = '0;
        chk("rr_rsp_last", 256'(bus.rsp_valid), 256'(3'b100));

        // Port 1 read data held while port 0 streams reads (same split included)
        @(negedge clk);
        bus.req_valid[1] = 1'b1; bus.req_rw[1] = 1'b0; bus.req_addr[1] = 10'h020;
        #1;
        chk("hold_ready1", 256'(bus.req_ready[1]), 256'(1));
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            bus.req_valid[0] = 1'b1; bus.req_rw[0] = 1'b0;
            bus.req_addr[0] = (c % 2 == 0) ? 10'h028 : 10'h029;
            #1;
            if (bus.rsp_valid[1]) pulses++;
            chk($sformatf("hold_dout1_%0d", c), bus.rsp_dout[1], c_d20);
            if (c > 0) begin
                chk($sformatf("b2b_valid0_%0d", c), 256'(bus.rsp_valid[0]), 256'(1));
                chk($sformatf("b2b_dout0_%0d", c), bus.rsp_dout[0], ((c - 1) % 2 == 0) ? c_d28 : c_d29);
            end
            @(negedge clk);
        end
        bus.req_valid[0] = 1'b0;
        #1;
        if (bus.rsp_valid[1]) pulses++;
        chk("hold_pulses1", 256'(pulses), 256'(1));
        chk("b2b_dout0_last", bus.rsp_dout[0], c_d29);

        // Write then read of the same word on consecutive cycles
        @(negedge clk);
        bus.req_valid[0] = 1'b1; bus.req_rw[0] = 1'b1; bus.req_addr[0] = 10'h040;
        bus.req_din[0] = c_d40; bus.req_byte_mask[0] = c_full;
        #1;
        chk("raw_wr_ready", 256'(bus.req_ready[0]), 256'(1));
        @(negedge clk);
        chk("raw_wr_no_rsp", 256'(bus.rsp_valid[0]), '0);
        chk("raw_wr_dout_kept", bus.rsp_dout[0], c_d29);
        bus.req_rw[0] = 1'b0;
        #1;
        chk("raw_rd_ready", 256'(bus.req_ready[0]), 256'(1));
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        chk("raw_rd_valid", 256'(bus.rsp_valid[0]), 256'(1));
        chk("raw_rd_dout", bus.rsp_dout[0], c_d40);

        // Low power: no grants; a read granted just before still responds
        @(negedge clk);
        slp = 1'b1;
        bus.req_valid[0] = 1'b1; bus.req_rw[0] = 1'b0; bus.req_addr[0] = 10'h012;
        #1;
        chk("slp_ready", 256'(bus.req_ready), '0);
        @(negedge clk);
        chk("slp_no_rsp", 256'(bus.rsp_valid[0]), '0);
        slp = 1'b0; pwr_down = 1'b1;
        #1;
        chk("pd_ready", 256'(bus.req_ready), '0);
        @(negedge clk);
        pwr_down = 1'b0;
        #1;
        chk("wake_ready", 256'(bus.req_ready[0]), 256'(1));
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        slp = 1'b1;
        #1;
        chk("slp_late_valid", 256'(bus.rsp_valid[0]), 256'(1));
        chk("slp_late_dout", bus.rsp_dout[0], c_d12);
        @(negedge clk);
        slp = 1'b0;

        // Reset right after a read grant
        @(negedge clk);
        bus.req_valid[0] = 1'b1; bus.req_rw[0] = 1'b0; bus.req_addr[0] = 10'h005;
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        chk("mid_rsp_before_rst", 256'(bus.rsp_valid[0]), 256'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 256'(bus.rsp_valid), '0);
        for (int p = 0; p < 3; p++) chk($sformatf("mid_rst_dout%0d", p), bus.rsp_dout[p], '0);
        @(negedge clk);
        rst = 1'b0;
        op(vecs[1], 100);
        op(mk(2, 1'b0, 10'h040, '0, '0, c_d40), 101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
